// File: rtl/magic_square_seq_checker.sv
// Streaming NxN magic-square checker: cells arrive row-major over a
// valid/ready handshake, line sums are accumulated on the fly, then a
// short compare phase walks the column sums and both diagonals.
module magic_square_seq_checker #(
    parameter int N = 3,
    parameter int W = 4,
    localparam int SW = W + $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          start,
    input  logic          abort,
    input  logic          cell_valid,
    input  logic [W-1:0]  cell_data,
    output logic          cell_ready,
    output logic          busy,
    output logic          done,
    output logic          it_is_magic,
    output logic [SW-1:0] magic_constant
);

    localparam int CW = $clog2(N);      // row/column index width
    localparam int KW = $clog2(N + 1);  // compare index width, counts 0..N

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   r_reg, c_reg;
    logic [KW-1:0]   k_reg;
    logic [SW-1:0]   row_acc_reg, diag_reg, anti_reg, magic_reg;
    logic            mismatch_reg, is_magic_reg, done_reg;
    logic [SW-1:0]   col_sum [N];
    logic [SW-1:0]   col_sel;
    logic [SW-1:0]   cell_ext, row_total;
    logic            xfer, start_accept, last_col, last_row, on_diag, on_anti;
    logic [CW:0]     rc_sum;

    assign cell_ext     = SW'(cell_data);
    assign xfer         = cell_valid && (state_reg == S_LOAD);
    assign start_accept = (state_reg == S_IDLE) && start && !abort;
    assign last_col     = (c_reg == CW'(N - 1));
    assign last_row     = (r_reg == CW'(N - 1));
    assign on_diag      = (r_reg == c_reg);
    assign rc_sum       = {1'b0, r_reg} + {1'b0, c_reg};
    assign on_anti      = (rc_sum == (CW + 1)'(N - 1));
    // Row sum including the cell being transferred this cycle.
    assign row_total    = row_acc_reg + cell_ext;

    assign done           = done_reg;
    assign it_is_magic    = is_magic_reg;
    assign magic_constant = magic_reg;

    // State register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    // Next-state decode and state-derived handshake outputs; abort overrides all.
    always_comb begin
        state_next = state_reg;
        cell_ready = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD: begin
                cell_ready = 1'b1;
                busy       = 1'b1;
                if (xfer && last_col && last_row) state_next = S_CHECK;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (k_reg == KW'(N)) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    // One accumulator per column; each only listens when the column index matches.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_col
            logic [SW-1:0] sum_reg;
            // Column accumulator, cleared at the start of every square.
            always_ff @(posedge clock or negedge reset_L) begin
                if (!reset_L)
                    sum_reg <= '0;
                else if (abort || start_accept)
                    sum_reg <= '0;
                else if (xfer && (c_reg == CW'(gi)))
                    sum_reg <= sum_reg + cell_ext;
            end
            assign col_sum[gi] = sum_reg;
        end
    endgenerate

    // Select the column sum under test during the compare phase.
    always_comb begin
        col_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (k_reg == KW'(i)) col_sel = col_sum[i];
        end
    end

    // Datapath: counters, row/diagonal accumulators, mismatch flag and results.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_reg        <= '0;
            c_reg        <= '0;
            k_reg        <= '0;
            row_acc_reg  <= '0;
            diag_reg     <= '0;
            anti_reg     <= '0;
            magic_reg    <= '0;
            mismatch_reg <= 1'b0;
            is_magic_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else if (abort) begin
            r_reg        <= '0;
            c_reg        <= '0;
            k_reg        <= '0;
            row_acc_reg  <= '0;
            diag_reg     <= '0;
            anti_reg     <= '0;
            magic_reg    <= '0;
            mismatch_reg <= 1'b0;
            is_magic_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            // done is registered off the DONE state, so it lands one edge later.
            done_reg <= (state_reg == S_DONE);
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        r_reg        <= '0;
                        c_reg        <= '0;
                        k_reg        <= '0;
                        row_acc_reg  <= '0;
                        diag_reg     <= '0;
                        anti_reg     <= '0;
                        magic_reg    <= '0;
                        mismatch_reg <= 1'b0;
                        is_magic_reg <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        if (on_diag) diag_reg <= diag_reg + cell_ext;
                        if (on_anti) anti_reg <= anti_reg + cell_ext;
                        if (last_col) begin
                            c_reg       <= '0;
                            r_reg       <= r_reg + 1'b1;
                            row_acc_reg <= '0;
                            // Row 0 defines the target; later rows are compared against it.
                            if (r_reg == '0)
                                magic_reg <= row_total;
                            else if (row_total != magic_reg)
                                mismatch_reg <= 1'b1;
                        end else begin
                            c_reg       <= c_reg + 1'b1;
                            row_acc_reg <= row_total;
                        end
                    end
                end
                S_CHECK: begin
                    k_reg <= k_reg + 1'b1;
                    if (k_reg < KW'(N)) begin
                        if (col_sel != magic_reg) mismatch_reg <= 1'b1;
                    end else begin
                        if ((diag_reg != magic_reg) || (anti_reg != magic_reg))
                            mismatch_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    is_magic_reg <= !mismatch_reg;
                end
                default: ;
            endcase
        end
    end

endmodule
